// File: rtl/wb_conv1d_engine.sv
// Wishbone-attached 1-D FIR/convolution engine: coefficient RAM, input/output
// sample FIFOs and a single-multiplier MAC sequenced by a four-state FSM.

module wb_conv1d_fifo #(
    parameter int unsigned W     = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             head_c,
    output logic                     full_c,
    output logic                     empty_c,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    assign head_c  = mem[rd_ptr];
    assign full_c  = (count == CNT_W'(DEPTH));
    assign empty_c = (count == '0);

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    // Clear has priority over any push/pop landing on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end
endmodule

module wb_conv1d_engine #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned TAPS       = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0000
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic [2:0]  irq
);
    localparam int unsigned K_W    = $clog2(TAPS);
    localparam int unsigned PROD_W = 2 * DATA_W;
    localparam int unsigned ACC_W  = PROD_W + K_W;
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;

    localparam logic [7:0] OFF_CTRL   = 8'h00;
    localparam logic [7:0] OFF_STATUS = 8'h04;
    localparam logic [7:0] OFF_DIN    = 8'h08;
    localparam logic [7:0] OFF_DOUT   = 8'h0C;
    localparam logic [7:0] OFF_COEF   = 8'h40;

    typedef enum logic [1:0] {IDLE, LOAD, MAC, STORE} state_t;

    state_t state_q, state_d;

    logic                     en, irq_en, err;
    logic signed [DATA_W-1:0] coef [TAPS];
    logic signed [DATA_W-1:0] hist [TAPS];
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [PROD_W-1:0] prod;
    logic [K_W-1:0]           k_q;

    logic [7:0]       off;
    logic             req, wr, rd, busy, clr;
    logic             din_wr, dout_rd, coef_wr, is_coef, err_set;
    logic [5:0]       coef_idx;
    logic [K_W-1:0]   coef_k;
    logic [31:0]      rd_data;
    logic [31:0]      result;

    logic             in_push, in_pop, in_full, in_empty;
    logic [DATA_W-1:0] in_head;
    logic [CNT_W-1:0] unused_in_count;
    logic             out_push, out_pop, out_full, out_empty;
    logic [31:0]      out_head;
    logic [CNT_W-1:0] out_count;
    logic             unused_ok;

    assign unused_ok = ^{wbs_sel_i, wbs_dat_i};

    // Address decode; a new access is only taken while ack is low.
    assign off      = wbs_adr_i[7:0];
    assign req      = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]) & ~wbs_ack_o;
    assign wr       = req & wbs_we_i;
    assign rd       = req & ~wbs_we_i;
    assign coef_idx = 6'(off[7:2] - 6'h10);
    assign coef_k   = coef_idx[K_W-1:0];
    assign is_coef  = (off >= OFF_COEF) && (off[1:0] == 2'b00) && (32'(coef_idx) < TAPS);
    assign busy     = (state_q != IDLE);

    assign clr      = wr & (off == OFF_CTRL) & wbs_dat_i[1];
    assign din_wr   = wr & (off == OFF_DIN);
    assign dout_rd  = rd & (off == OFF_DOUT);
    assign coef_wr  = wr & is_coef;
    assign in_push  = din_wr & ~in_full;
    assign out_pop  = dout_rd & ~out_empty;
    assign err_set  = (din_wr & in_full) | (dout_rd & out_empty) | (coef_wr & busy);

    assign irq      = {1'b0, irq_en & err, irq_en & ~out_empty};

    wb_conv1d_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_in_fifo (
        .clk(wb_clk_i), .rst(wb_rst_i), .clr(clr),
        .push(in_push), .pop(in_pop), .din(wbs_dat_i[DATA_W-1:0]),
        .head_c(in_head), .full_c(in_full), .empty_c(in_empty), .count(unused_in_count)
    );

    wb_conv1d_fifo #(.W(32), .DEPTH(FIFO_DEPTH)) u_out_fifo (
        .clk(wb_clk_i), .rst(wb_rst_i), .clr(clr),
        .push(out_push), .pop(out_pop), .din(result),
        .head_c(out_head), .full_c(out_full), .empty_c(out_empty), .count(out_count)
    );

    always_comb begin
        rd_data = '0;
        case (off)
            OFF_CTRL:   rd_data = {29'd0, irq_en, 1'b0, en};
            OFF_STATUS: rd_data = {16'd0, 8'(out_count), 3'd0, err, ~out_empty,
                                   in_empty, in_full, busy};
            OFF_DOUT:   if (!out_empty) rd_data = out_head;
            default:    if (is_coef) rd_data = 32'(coef[coef_k]);
        endcase
    end

    // Bus side: ack/read data, control, sticky error and coefficient store.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
            en        <= 1'b0;
            irq_en    <= 1'b0;
            err       <= 1'b0;
            for (int unsigned i = 0; i < TAPS; i++) coef[K_W'(i)] <= '0;
        end else begin
            wbs_ack_o <= req;
            wbs_dat_o <= rd ? rd_data : '0;
            if (wr && (off == OFF_CTRL)) begin
                en     <= wbs_dat_i[0];
                irq_en <= wbs_dat_i[2];
            end
            if (err_set) err <= 1'b1;
            else if (wr && (off == OFF_STATUS) && wbs_dat_i[4]) err <= 1'b0;
            if (coef_wr && !busy) coef[coef_k] <= wbs_dat_i[DATA_W-1:0];
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        in_pop   = 1'b0;
        out_push = 1'b0;
        case (state_q)
            IDLE:  if (en && !in_empty && !out_full) state_d = LOAD;
            LOAD:  begin
                in_pop  = 1'b1;
                state_d = MAC;
            end
            MAC:   if (k_q == K_W'(TAPS - 1)) state_d = STORE;
            STORE: begin
                out_push = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (clr) state_d = IDLE;
    end

    assign prod   = PROD_W'(coef[k_q]) * PROD_W'(hist[k_q]);
    assign result = 32'(acc_q);

    // History shift on LOAD, one tap per cycle in MAC; CLR aborts and zeroes.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            for (int unsigned i = 0; i < TAPS; i++) hist[K_W'(i)] <= '0;
            acc_q <= '0;
            k_q   <= '0;
        end else if (clr) begin
            for (int unsigned i = 0; i < TAPS; i++) hist[K_W'(i)] <= '0;
            acc_q <= '0;
            k_q   <= '0;
        end else begin
            case (state_q)
                LOAD: begin
                    hist[0] <= in_head;
                    for (int unsigned i = 1; i < TAPS; i++) hist[K_W'(i)] <= hist[K_W'(i - 1)];
                    acc_q <= '0;
                    k_q   <= '0;
                end
                MAC: begin
                    acc_q <= acc_q + ACC_W'(prod);
                    k_q   <= k_q + K_W'(1);
                end
                default: ;
            endcase
        end
    end
endmodule
